// File: rtl/random_sequence_counter_pkg.sv
// Shared constants and the next-value function for the six-step sequence counter.
package random_counter_pkg;

   localparam int CNT_W = 3;

   localparam logic [CNT_W-1:0] SEQ [0:5] = '{3'd0, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2};
   localparam logic [CNT_W-1:0] LAST = 3'd2;

   // Returns {illegal, in}; a code absent from SEQ (including X) yields illegal with in=0.
   function automatic logic [CNT_W:0] next_val(input logic [CNT_W-1:0] count);
      logic [CNT_W:0] res;
      res = {1'b1, 3'd0};
      for (int i = 0; i < 6; i++) begin
         if (count == SEQ[i]) begin
            res = {1'b0, SEQ[(i + 1) % 6]};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/random_sequence_counter_if.sv
// Output bundle of the sequence counter: current value and the wrap flag.
interface random_sequence_counter_if;
   import random_counter_pkg::*;

   logic [CNT_W-1:0] count;
   logic             wrap;

   modport master (output count, output wrap);
   modport slave  (input count, input wrap);
endinterface

// File: rtl/random_sequence_counter_seq_controller.sv
// Combinational next-state controller: maps the current count to its successor.
module seq_controller
   import random_counter_pkg::*;
(
   input  logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] in,
   output logic             illegal
);

   logic [CNT_W:0] nv_s;

   // Table lookup; codes 4, 7 and unknown values flag illegal and load 0.
   always_comb begin
      nv_s    = next_val(count);
      illegal = nv_s[CNT_W];
      in      = nv_s[CNT_W-1:0];
   end

endmodule

// File: rtl/random_sequence_counter.sv
// Six-step non-binary counter 0,3,5,1,6,2: load register plus combinational controller.
module random_sequence_counter
   import random_counter_pkg::*;
(
   input  logic                      clk,
   input  logic                      clear,
   random_sequence_counter_if.master bus
);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] in_s;
   logic             illegal_s;
   logic             clr_int_s;

   seq_controller u_ctrl (
      .count   (count_r),
      .in      (in_s),
      .illegal (illegal_s)
   );

   // An illegal code is cleared the same way as an external clear.
   assign clr_int_s = clear | illegal_s;

   // Count register: synchronous clear, otherwise load the controller's successor.
   always_ff @(posedge clk) begin
      if (clr_int_s) begin
         count_r <= 3'd0;
      end else begin
         count_r <= in_s;
      end
   end

   assign bus.count = count_r;
   assign bus.wrap  = (count_r == LAST);

endmodule

// File: tb/tb_random_sequence_counter.sv
// Directed bench for random_sequence_counter and its seq_controller.
module tb_random_sequence_counter;

   logic       clk;
   logic       clear;
   int         chk_cnt;
   int         pass_cnt;

   random_sequence_counter_if bus ();

   random_sequence_counter dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   logic [2:0] ctl_count;
   logic [2:0] ctl_in;
   logic       ctl_illegal;

   seq_controller u_ctl (
      .count   (ctl_count),
      .in      (ctl_in),
      .illegal (ctl_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge, then compare count and wrap against the expected value.
   task automatic step(input string tag, input logic [2:0] exp_c);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_count"}, {1'b0, bus.count}, {1'b0, exp_c});
      check({tag, "_wrap"}, {3'b000, bus.wrap}, {3'b000, (exp_c == 3'd2)});
   endtask

   task automatic wait_count(input string tag, input logic [2:0] v);
      int n;
      n = 0;
      while (bus.count !== v && n < 12) begin
         @(negedge clk);
         n++;
      end
      check(tag, {1'b0, bus.count}, {1'b0, v});
   endtask

   // Force an illegal code into the register mid-cycle and check recovery.
   task automatic inject(input string tag, input logic [2:0] bad);
      force dut.count_r = bad;
      #1;
      check({tag, "_forced"}, {1'b0, bus.count}, {1'b0, bad});
      check({tag, "_flag"}, {3'b000, dut.illegal_s}, 4'd1);
      #2;
      release dut.count_r;
      step({tag, "_rec"}, 3'd0);
      step({tag, "_s1"}, 3'd3);
      step({tag, "_s2"}, 3'd5);
   endtask

   logic [3:0] ctl_exp [0:7];
   int         wrap_n;
   int         bad_n;
   int         first_w;
   int         last_w;

   initial begin
      chk_cnt  = 0;
      pass_cnt = 0;
      clear    = 1'b0;
      ctl_count = 3'd0;

      // Power-up without clear: whatever the start value, the next one is legal.
      @(posedge clk);
      @(negedge clk);
      check("pwrup_legal", {3'b000, (bus.count != 3'd4 && bus.count != 3'd7)}, 4'd1);

      clear = 1'b1;
      step("rst0", 3'd0);
      step("rst1", 3'd0);
      clear = 1'b0;

      step("seq0", 3'd3);
      step("seq1", 3'd5);
      step("seq2", 3'd1);
      step("seq3", 3'd6);
      step("seq4", 3'd2);
      step("seq5", 3'd0);
      step("seq6", 3'd3);

      // Free run: wrap every 6 cycles, never 4 or 7.
      wrap_n  = 0;
      bad_n   = 0;
      first_w = -1;
      last_w  = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.count == 3'd4 || bus.count == 3'd7) bad_n++;
         if (bus.wrap) begin
            wrap_n++;
            if (first_w < 0) first_w = i;
            last_w = i;
         end
         if (bus.wrap != (bus.count == 3'd2)) bad_n++;
      end
      check("run_illegal", bad_n[3:0], 4'd0);
      check("run_wraps", wrap_n[3:0], 4'd3);
      check("run_first", first_w[3:0], 4'd3);
      check("run_period", 4'(last_w - first_w), 4'd12);
      check("run_end", {1'b0, bus.count}, 4'd1);

      // Clear mid-sequence at 5.
      wait_count("wait5", 3'd5);
      clear = 1'b1;
      step("clr5", 3'd0);
      clear = 1'b0;
      step("clr5_next", 3'd3);

      // Clear coinciding with the wrap step: no double step.
      wait_count("wait2", 3'd2);
      clear = 1'b1;
      step("clr2", 3'd0);
      clear = 1'b0;
      step("clr2_next", 3'd3);
      step("clr2_next2", 3'd5);

      inject("force7", 3'd7);
      inject("force4", 3'd4);

      // Exhaustive controller table.
      ctl_exp[0] = 4'b0011;
      ctl_exp[1] = 4'b0110;
      ctl_exp[2] = 4'b0000;
      ctl_exp[3] = 4'b0101;
      ctl_exp[4] = 4'b1000;
      ctl_exp[5] = 4'b0001;
      ctl_exp[6] = 4'b0010;
      ctl_exp[7] = 4'b1000;
      for (int k = 0; k < 8; k++) begin
         ctl_count = 3'(k);
         #1;
         check($sformatf("ctl_%0d", k), {ctl_illegal, ctl_in}, ctl_exp[k]);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
